// File: rtl/fp_sub_arb_pkg.sv
// Shared types and FP32 constants for the fp_sub_arbiter slice and its benches.
package fp_sub_arb_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ISSUE     = 3'd1,
        WAIT_CLR  = 3'd2,
        WAIT_DONE = 3'd3,
        RESP      = 3'd4
    } arb_state_t;

    localparam logic [31:0] FP32_QNAN = 32'h7FC00000;
    localparam logic [31:0] FP32_ONE  = 32'h3f800000;
    localparam logic [31:0] FP32_TWO  = 32'h40000000;

endpackage

// File: rtl/fp_rr_pick.sv
// Combinational rotate-priority picker: first set request searching upward from ptr, wrapping at N-1.
module fp_rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             any
);

    int idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any       = 1'b0;
        idx       = 0;
        for (int off = 0; off < N; off++) begin
            idx = (int'(ptr) + off) % N;
            if (!any && req[idx]) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/fp_sub_arbiter.sv
// Round-robin front end sharing one start/busy/sticky-done FP32 subtractor between NUM_REQ requesters.
// Optional WAIT_DONE watchdog is enabled by defining FP_SUB_ARB_TIMEOUT_EN.
module fp_sub_arbiter
    import fp_sub_arb_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int ID_W           = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [NUM_REQ*32-1:0] req_a,
    input  logic [NUM_REQ*32-1:0] req_b,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [ID_W-1:0]       rsp_id,
    output logic [31:0]           rsp_z,
    output logic                  rsp_err,
    output logic                  sub_start,
    output logic [31:0]           sub_a_bits,
    output logic [31:0]           sub_b_bits,
    input  logic                  sub_busy,
    input  logic                  sub_done,
    input  logic [31:0]           sub_z_bits
);

    if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_cfg
        $error("fp_sub_arbiter: parameter out of range");
    end

    arb_state_t        state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]   id_q, id_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic [31:0]       z_q, z_d;
    logic              rsp_valid_q, rsp_valid_d;

    logic [NUM_REQ-1:0] pick_grant;
    logic [ID_W-1:0]    pick_idx;
    logic               pick_any;
    logic               grant_en;

`ifdef FP_SUB_ARB_TIMEOUT_EN
    localparam logic [15:0] TO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic        err_q, err_d;
    logic [15:0] cnt_q, cnt_d;
`endif

    fp_rr_pick #(
        .N     (NUM_REQ),
        .IDX_W (ID_W)
    ) u_pick (
        .req       (req_valid),
        .ptr       (rr_ptr_q),
        .grant     (pick_grant),
        .grant_idx (pick_idx),
        .any       (pick_any)
    );

    // Gating with rst_n keeps req_ready at zero while reset is held, not just after the first edge.
    assign grant_en  = rst_n && (state_q == IDLE) && !sub_busy && pick_any;
    assign req_ready = grant_en ? pick_grant : '0;

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        id_d        = id_q;
        a_d         = a_q;
        b_d         = b_q;
        z_d         = z_q;
        rsp_valid_d = rsp_valid_q;
`ifdef FP_SUB_ARB_TIMEOUT_EN
        err_d       = err_q;
        cnt_d       = cnt_q;
`endif
        case (state_q)
            IDLE: begin
                if (grant_en) begin
                    a_d      = req_a[32*pick_idx +: 32];
                    b_d      = req_b[32*pick_idx +: 32];
                    id_d     = pick_idx;
                    rr_ptr_d = (int'(pick_idx) == NUM_REQ - 1) ? '0 : pick_idx + ID_W'(1);
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                state_d = WAIT_CLR;
            end
            WAIT_CLR: begin
                // A done still high here belongs to the previous operation.
                if (!sub_done) begin
                    state_d = WAIT_DONE;
`ifdef FP_SUB_ARB_TIMEOUT_EN
                    cnt_d   = '0;
`endif
                end
            end
            WAIT_DONE: begin
                if (sub_done) begin
                    z_d         = sub_z_bits;
                    rsp_valid_d = 1'b1;
                    state_d     = RESP;
`ifdef FP_SUB_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    z_d         = FP32_QNAN;
                    rsp_valid_d = 1'b1;
                    err_d       = 1'b1;
                    state_d     = RESP;
                end else begin
                    cnt_d       = cnt_q + 16'd1;
`endif
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = IDLE;
`ifdef FP_SUB_ARB_TIMEOUT_EN
                    err_d       = 1'b0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            id_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            z_q         <= '0;
            rsp_valid_q <= 1'b0;
`ifdef FP_SUB_ARB_TIMEOUT_EN
            err_q       <= 1'b0;
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            id_q        <= id_d;
            a_q         <= a_d;
            b_q         <= b_d;
            z_q         <= z_d;
            rsp_valid_q <= rsp_valid_d;
`ifdef FP_SUB_ARB_TIMEOUT_EN
            err_q       <= err_d;
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign sub_start  = (state_q == ISSUE);
    assign sub_a_bits = a_q;
    assign sub_b_bits = b_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_id     = id_q;
    assign rsp_z      = z_q;
`ifdef FP_SUB_ARB_TIMEOUT_EN
    assign rsp_err    = err_q;
`else
    assign rsp_err    = 1'b0;
`endif

endmodule

// File: tb/tb_fp_sub_arbiter.sv
// Bench for fp_sub_arbiter: behavioural subtractor stub, requester queues and a response scoreboard.
module tb_fp_sub_arbiter;
    import fp_sub_arb_pkg::*;

    localparam int NUM = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NUM-1:0]    req_valid;
    logic [NUM-1:0]    req_ready;
    logic [NUM*32-1:0] req_a, req_b;
    logic              rsp_valid, rsp_ready, rsp_err;
    logic [1:0]        rsp_id;
    logic [31:0]       rsp_z;
    logic              sub_start, sub_busy, sub_done;
    logic [31:0]       sub_a_bits, sub_b_bits, sub_z_bits;

    logic        drv_busy, tb_busy, drv_stall, drv_late_clr, drv_clr_pend;
    logic [1:0]  drv_cnt;
    logic [31:0] drv_a, drv_b;

    int vectors = 0;
    int miscompares = 0;
    int starts = 0;
    int ptr_m = 0;
    logic [31:0] last_z;

    logic [31:0] qa[NUM][$];
    logic [31:0] qb[NUM][$];
    int          sb_id[$];
    logic [31:0] sb_z[$];

    always #5 clk = ~clk;

    fp_sub_arbiter #(.NUM_REQ(NUM), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_z(rsp_z), .rsp_err(rsp_err),
        .sub_start(sub_start), .sub_a_bits(sub_a_bits), .sub_b_bits(sub_b_bits),
        .sub_busy(sub_busy), .sub_done(sub_done), .sub_z_bits(sub_z_bits)
    );

    // Result of the stub subtractor: exact FP32 answers for the known pairs, an asymmetric token otherwise.
    function automatic logic [31:0] ref_sub(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h3f800000}: ref_sub = 32'h3f800000;
            {32'h40600000, 32'h3fa00000}: ref_sub = 32'h40100000;
            {32'h3f800000, 32'hbf800000}: ref_sub = 32'h40000000;
            {32'h00000000, 32'h40a00000}: ref_sub = 32'hc0a00000;
            {32'h40a00000, 32'h00000000}: ref_sub = 32'h40a00000;
            {32'h3f800000, 32'h40000000}: ref_sub = 32'hbf800000;
            {32'h7f800000, 32'h7f800000}: ref_sub = 32'h7fc00000;
            default:                      ref_sub = a ^ {b[7:0], b[31:8]} ^ 32'h5a5a0000;
        endcase
    endfunction

    // Driver stub: start/busy/sticky-done, optional late clear of done, optional stall.
    assign sub_busy = drv_busy | tb_busy;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drv_busy <= 1'b0; sub_done <= 1'b0; sub_z_bits <= '0; drv_cnt <= '0;
            drv_clr_pend <= 1'b0; drv_a <= '0; drv_b <= '0;
        end else if (sub_start) begin
            drv_busy <= 1'b1; drv_cnt <= 2'($urandom_range(0, 3));
            drv_a <= sub_a_bits; drv_b <= sub_b_bits;
            if (drv_late_clr) drv_clr_pend <= 1'b1;
            else sub_done <= 1'b0;
        end else if (drv_clr_pend) begin
            sub_done <= 1'b0; drv_clr_pend <= 1'b0;
        end else if (drv_busy && !drv_stall) begin
            if (drv_cnt == 2'd0) begin
                drv_busy <= 1'b0; sub_done <= 1'b1; sub_z_bits <= ref_sub(drv_a, drv_b);
            end else begin
                drv_cnt <= drv_cnt - 2'd1;
            end
        end
    end

    function automatic bit pending();
        pending = 1'b0;
        for (int i = 0; i < NUM; i++) if (qa[i].size() != 0) pending = 1'b1;
    endfunction

    function automatic int exp_winner(input logic [NUM-1:0] v, input int p);
        exp_winner = -1;
        for (int k = NUM - 1; k >= 0; k--) if (v[(p + k) % NUM]) exp_winner = (p + k) % NUM;
    endfunction

    task automatic push_op(input int r, input logic [31:0] a, input logic [31:0] b);
        qa[r].push_back(a);
        qb[r].push_back(b);
    endtask

    // mode 0: requesters always valid, rsp_ready high; mode 1: random valid drops and backpressure.
    task automatic run(input int mode, input int budget);
        int cyc, w, ew;
        cyc = 0;
        while (cyc < budget && (pending() || sb_id.size() != 0)) begin
            @(negedge clk);
            for (int i = 0; i < NUM; i++) begin
                if (qa[i].size() != 0 && (mode == 0 || $urandom_range(0, 3) != 0)) begin
                    req_valid[i] = 1'b1;
                    req_a[32*i +: 32] = qa[i][0];
                    req_b[32*i +: 32] = qb[i][0];
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            rsp_ready = (mode == 0) ? 1'b1 : ($urandom_range(0, 2) != 0);
            #1;
            if (sub_start) starts++;
            if (req_ready != '0) begin
                w = -1;
                for (int i = 0; i < NUM; i++) if (req_ready[i]) w = i;
                ew = exp_winner(req_valid, ptr_m);
                vectors++;
                if ($countones(req_ready) != 1 || w != ew || (req_ready & ~req_valid) != '0) begin
                    miscompares++;
                    $display("FAIL grant: req_ready=%b req_valid=%b expected winner %0d", req_ready, req_valid, ew);
                end
                if (w >= 0 && qa[w].size() != 0) begin
                    sb_id.push_back(w);
                    sb_z.push_back(ref_sub(qa[w][0], qb[w][0]));
                    void'(qa[w].pop_front());
                    void'(qb[w].pop_front());
                    ptr_m = (w + 1) % NUM;
                end
            end
            if (rsp_valid && rsp_ready) begin
                vectors++;
                if (sb_id.size() == 0) begin
                    miscompares++;
                    $display("FAIL rsp_unexpected: id=%0d z=%h with no request outstanding", rsp_id, rsp_z);
                end else begin
                    if (int'(rsp_id) != sb_id[0] || rsp_z !== sb_z[0] || rsp_err !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rsp: id=%0d z=%h err=%b expected id=%0d z=%h err=0",
                                 rsp_id, rsp_z, rsp_err, sb_id[0], sb_z[0]);
                    end
                    last_z = rsp_z;
                    void'(sb_id.pop_front());
                    void'(sb_z.pop_front());
                end
            end
            cyc++;
        end
        req_valid = '0;
        if (pending() || sb_id.size() != 0) begin
            vectors++; miscompares++;
            $display("FAIL run_timeout: %0d responses outstanding after %0d cycles, expected 0", sb_id.size(), cyc);
            sb_id.delete(); sb_z.delete();
            for (int i = 0; i < NUM; i++) begin qa[i].delete(); qb[i].delete(); end
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        vectors++;
        if (req_ready !== '0 || rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_z !== '0 || rsp_err !== 1'b0 ||
            sub_start !== 1'b0 || sub_a_bits !== '0 || sub_b_bits !== '0) begin
            miscompares++;
            $display("FAIL %s: ready=%b rv=%b id=%0d z=%h err=%b start=%b a=%h b=%h, all required 0",
                     tag, req_ready, rsp_valid, rsp_id, rsp_z, rsp_err, sub_start, sub_a_bits, sub_b_bits);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = '1; req_a = {4{32'h12345678}}; req_b = {4{32'h9abcdef0}}; rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check_zero_outputs("reset");
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
    endtask

    task automatic test_single();
        starts = 0;
        push_op(0, FP32_TWO, FP32_ONE);
        run(0, 100);
        vectors++;
        if (starts != 1 || last_z !== 32'h3f800000) begin
            miscompares++;
            $display("FAIL single: starts=%0d z=%h, required 1 and 3f800000", starts, last_z);
        end
    endtask

    task automatic test_busy_block();
        tb_busy = 1'b1;
        @(negedge clk);
        req_valid = 4'b0101;
        req_a[31:0] = FP32_TWO; req_b[31:0] = FP32_ONE;
        #1;
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (req_ready !== '0 || sub_start !== 1'b0) begin
                miscompares++;
                $display("FAIL busy_block: req_ready=%b start=%b while busy, required 0", req_ready, sub_start);
            end
            @(negedge clk); #1;
        end
        tb_busy = 1'b0;
        req_valid = '0;
        push_op(2, FP32_ONE, 32'hbf800000);
        run(0, 100);
    endtask

    task automatic test_round_robin();
        starts = 0;
        for (int n = 0; n < 2; n++) begin
            push_op(0, 32'h40600000, 32'h3fa00000);
            push_op(1, 32'h3f800000, 32'hbf800000);
            push_op(2, 32'h00000000, 32'h40a00000);
            push_op(3, 32'h40a00000, 32'h00000000);
        end
        run(0, 300);
        vectors++;
        if (starts != 8) begin
            miscompares++;
            $display("FAIL rr_starts: %0d start pulses, required 8", starts);
        end
    endtask

    task automatic test_rsp_hold();
        int cyc;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b1000;
        req_a[96 +: 32] = 32'h40a00000; req_b[96 +: 32] = 32'h00000000;
        #1;
        cyc = 0;
        while (req_ready !== 4'b1000 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        vectors++;
        if (req_ready !== 4'b1000) begin
            miscompares++;
            $display("FAIL hold_grant: req_ready=%b, required 1000", req_ready);
        end
        ptr_m = 0;
        @(negedge clk);
        req_valid = 4'b0010;
        req_a[32 +: 32] = FP32_TWO; req_b[32 +: 32] = FP32_ONE;
        #1;
        cyc = 0;
        while (rsp_valid !== 1'b1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        for (int k = 0; k < 10; k++) begin
            vectors++;
            if (rsp_valid !== 1'b1 || rsp_z !== 32'h40a00000 || rsp_id !== 2'd3 || rsp_err !== 1'b0 ||
                req_ready !== '0 || sub_start !== 1'b0) begin
                miscompares++;
                $display("FAIL hold_stable: rv=%b z=%h id=%0d err=%b ready=%b start=%b, required 1/40a00000/3/0/0/0",
                         rsp_valid, rsp_z, rsp_id, rsp_err, req_ready, sub_start);
            end
            @(negedge clk); #1;
        end
        rsp_ready = 1'b1;
        #1;
        vectors++;
        if (req_ready !== '0) begin
            miscompares++;
            $display("FAIL hold_handshake_grant: req_ready=%b in handshake cycle, required 0", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++;
        if (rsp_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL hold_release: rsp_valid=%b after handshake, required 0", rsp_valid);
        end
        push_op(1, FP32_TWO, FP32_ONE);
        run(0, 100);
    endtask

    task automatic test_stale_done();
        starts = 0;
        drv_late_clr = 1'b1;
        push_op(2, FP32_ONE, FP32_TWO);
        push_op(2, 32'h7f800000, 32'h7f800000);
        run(0, 200);
        drv_late_clr = 1'b0;
        vectors++;
        if (starts != 2 || last_z[30:23] !== 8'hff || last_z[22:0] == 23'd0) begin
            miscompares++;
            $display("FAIL stale_nan: starts=%0d z=%h, required 2 starts and a NaN", starts, last_z);
        end
    endtask

    task automatic test_random();
        int r;
        logic [31:0] a, b;
        starts = 0;
        for (int n = 0; n < 40; n++) begin
            r = $urandom_range(0, NUM - 1);
            if ($urandom_range(0, 1) == 0) begin
                a = 32'h40600000; b = 32'h3fa00000;
            end else begin
                a = $urandom; b = $urandom;
            end
            push_op(r, a, b);
        end
        run(1, 4000);
        vectors++;
        if (starts != 40) begin
            miscompares++;
            $display("FAIL random_starts: %0d start pulses, required 40", starts);
        end
    endtask

    task automatic test_reset_mid();
        int cyc;
        drv_stall = 1'b1;
        @(negedge clk);
        req_valid = 4'b0100;
        req_a[64 +: 32] = FP32_TWO; req_b[64 +: 32] = FP32_ONE;
        #1;
        cyc = 0;
        while (req_ready !== 4'b0100 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        req_valid = '0;
        #1;
        vectors++;
        if (sub_start !== 1'b1 || sub_a_bits !== FP32_TWO || sub_b_bits !== FP32_ONE) begin
            miscompares++;
            $display("FAIL mid_issue: start=%b a=%h b=%h, required 1/%h/%h", sub_start, sub_a_bits, sub_b_bits,
                     FP32_TWO, FP32_ONE);
        end
        repeat (3) @(negedge clk);
        req_valid = '1;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero_outputs("reset_mid");
        req_valid = '0;
        drv_stall = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        ptr_m = 0;
        sb_id.delete(); sb_z.delete();
        push_op(1, FP32_ONE, FP32_TWO);
        push_op(3, 32'h40600000, 32'h3fa00000);
        run(0, 200);
    endtask

`ifdef FP_SUB_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int cyc, gap;
        drv_stall = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 4'b0001;
        req_a[31:0] = FP32_TWO; req_b[31:0] = FP32_ONE;
        #1;
        cyc = 0;
        while (req_ready !== 4'b0001 && cyc < 50) begin @(negedge clk); #1; cyc++; end
        @(negedge clk);
        req_valid = '0;
        #1;
        gap = 0;
        while (rsp_valid !== 1'b1 && gap < 100) begin @(negedge clk); #1; gap++; end
        vectors++;
        if (gap != 18 || rsp_z !== FP32_QNAN || rsp_err !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout: start->rsp %0d cycles z=%h err=%b, required 18/%h/1", gap, rsp_z, rsp_err, FP32_QNAN);
        end
        rsp_ready = 1'b1;
        @(negedge clk); #1;
        vectors++;
        if (rsp_valid !== 1'b0 || rsp_err !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout_clear: rv=%b err=%b after handshake, required 0/0", rsp_valid, rsp_err);
        end
        drv_stall = 1'b0;
    endtask
`endif

    initial begin
        tb_busy = 1'b0; drv_stall = 1'b0; drv_late_clr = 1'b0;
        req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b0; last_z = '0;
        test_reset();
        test_single();
        test_busy_block();
        test_round_robin();
        test_rsp_hold();
        test_stale_done();
        test_random();
        test_reset_mid();
`ifdef FP_SUB_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation still running at %0t, required to have finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/fp_sub_arbiter.md
Name: fp_sub_arbiter

Overview:
- Shares one fp_subber_driver (start/busy/sticky-done, FP32 subtract) between NUM_REQ requesters.
- Selects a requester round-robin, latches its operands and issues one start pulse.
- Tracks the driver's sticky done (clears after start, then reasserts) and returns z on a shared response channel tagged with the requester ID.
- One operation is outstanding at a time; no pipelining across requests.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, $clog2(NUM_REQ), width of the requester ID.
- TIMEOUT_CYCLES, 4096, WAIT_DONE watchdog limit (used only with the optional feature).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero.
- req_a  in  NUM_REQ*32  minuends; slice i = bits [32*i+31:32*i].
- req_b  in  NUM_REQ*32  subtrahends, same slicing.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  requester index owning the response.
- rsp_z  out  32  result bits (a - b).
- rsp_err  out  1  timeout flag; tied 0 without the optional feature.
- sub_start  out  1  start pulse to the driver.
- sub_a_bits  out  32  latched operand a.
- sub_b_bits  out  32  latched operand b.
- sub_busy  in  1  driver busy.
- sub_done  in  1  driver sticky done.
- sub_z_bits  in  32  driver result.

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE, rr_ptr=0.
  - Outputs zero: req_ready, rsp_valid, rsp_id, rsp_z, rsp_err, sub_start, sub_a_bits, sub_b_bits.
  - Reset mid-operation abandons the request, with no response. The driver is reset from the same source.
- States: IDLE -> ISSUE -> WAIT_CLR -> WAIT_DONE -> RESP -> IDLE.
- IDLE:
  - When sub_busy=0 and any req_valid is set, pick the winner.
  - Winner = first set bit searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0.
  - req_ready[winner]=1 combinationally in that same cycle, so the handshake completes in that cycle.
  - On the handshake, at the clock edge: latch req_a/req_b slices into sub_a_bits/sub_b_bits and the winner into the ID register; set rr_ptr = (winner+1) mod NUM_REQ; go to ISSUE.
  - sub_busy=1 in IDLE blocks all grants; req_ready stays 0.
- ISSUE: sub_start=1 for exactly one cycle, then go to WAIT_CLR.
- WAIT_CLR: stay while sub_done=1; go to WAIT_DONE when sub_done=0.
  - This absorbs the stale done from the previous op.
  - The driver must clear done no later than the cycle after it samples start.
- WAIT_DONE:
  - Stay while sub_done=0.
  - When sub_done=1: rsp_z <= sub_z_bits, rsp_valid <= 1, go to RESP.
- RESP:
  - rsp_valid, rsp_id, rsp_z and rsp_err are held stable until rsp_ready=1.
  - On handshake: rsp_valid <= 0, go to IDLE. A new grant is possible at the earliest in the cycle after.
- Latency: accept -> rsp_valid = 3 + driver compute cycles minimum.
- Operands, ID and result are registered; sub_start is a registered state decode.
- Simultaneous requests: only one grant per op. Losers keep req_valid asserted; the requester must hold operands stable until its req_ready.
- req_valid dropped before grant: ignored without error.
- sub_done already 0 on entering WAIT_CLR (e.g. first op after reset): WAIT_CLR lasts exactly one cycle.

Optional Feature:
- Macro FP_SUB_ARB_TIMEOUT_EN.
- When defined:
  - A 16-bit counter clears on entry to WAIT_DONE and increments each cycle there.
  - When the counter reaches TIMEOUT_CYCLES with sub_done=0: go to RESP with rsp_z=32'h7FC00000 and rsp_err=1.
  - rsp_err clears with the rsp handshake.
- When undefined: no counter, rsp_err constant 0, and WAIT_DONE waits forever.

Decomposition:
- Package fp_sub_arb_pkg holds:
  - typedef enum logic [2:0] arb_state_t {IDLE, ISSUE, WAIT_CLR, WAIT_DONE, RESP};
  - localparam FP32_QNAN = 32'h7FC00000.
  - Constants FP32_ONE = 32'h3f800000 and FP32_TWO = 32'h40000000, shared with benches.
- Sub-module fp_rr_pick: combinational rotate-priority picker.
  - Inputs: req vector, ptr.
  - Outputs: one-hot grant, grant index, any.

Test Plan:
- Single requester 0: a=0x40000000, b=0x3f800000 -> exactly one sub_start pulse; rsp_valid with rsp_id=0, rsp_z=0x3f800000, rsp_err=0.
- All 4 requesters valid continuously, each with a different op (3.5-1.25 -> 0x40100000, 1.0-(-1.0) -> 0x40000000, 0-5 -> 0xc0a00000, 5-0 -> 0x40a00000) -> grant order 0,1,2,3,0,…; each rsp_id matches its result.
- rsp_ready held low 10 cycles after rsp_valid -> rsp_z/rsp_id stable, no new req_ready, no sub_start until the handshake.
- Stale done: back-to-back ops from requester 2 (1.0-2.0 then +inf-+inf) -> second op waits for done to fall then rise; results 0xbf800000 and a NaN (exp=0xFF, mant!=0).
- Assert rst_n=0 during WAIT_DONE -> all outputs 0 immediately (async); after release, a new request from requester 1 grants first from rr_ptr=0 and completes correctly.
- With FP_SUB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16 and a stubbed driver whose done never rises -> rsp_valid after 16 WAIT_DONE cycles, rsp_z=0x7FC00000, rsp_err=1.
